generador_trafico: RTL and testbench

Synthesizable, parametrised traffic generator and checker for the interconnect device (main FIFO → VC FIFOs → destination FIFOs). For each of N destination channels in turn, it fills the device with a sequence-numbered burst that respects `MAIN_FIFO_pause`, then drains that destination. In AUTO mode it drains concurrently with the fill. Every popped word is checked against the expected sequence, and pushed, popped and error totals are reported. It replaces the hand-written fill/drain benches and generalises them to any data width and channel count.

---
 rtl/generador_trafico_pkg.sv | 24 ++
 rtl/generador_trafico_if.sv | 32 +++
 rtl/generador_trafico_verificador_canal.sv | 57 +++++
 rtl/generador_trafico.sv | 189 ++++++++++++++++++
 tb/tb_generador_trafico.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/generador_trafico_pkg.sv
// Shared definitions for the traffic generator/checker.
//   state_t   : FSM encoding (IDLE, FILL, GAP, DRAIN, DONE)
//   make_word : builds a device word {channel, sequence} for any width up to 32 bits
package generador_trafico_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_GAP   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Channel goes in the bits above the sequence field; the sequence is
  // masked to seq_w bits so a wrapped counter never spills into the channel.
  function automatic logic [31:0] make_word(input logic [31:0] ch,
                                            input logic [31:0] seq,
                                            input int          seq_w);
    logic [31:0] mask;
    mask = (32'd1 << seq_w) - 32'd1;
    return (ch << seq_w) | (seq & mask);
  endfunction

endpackage

// File: rtl/generador_trafico_if.sv
// Bus between the traffic generator and the interconnect device.
//   master : generator side (drives data_in, push_data_in, pop)
//   slave  : device side (drives MAIN_FIFO_pause, empty, data_out)
//
// Handshake: push_data_in qualifies data_in for exactly one cycle. The
// device signals readiness with ~MAIN_FIFO_pause; the generator samples it
// on a clock edge and the resulting push appears registered in the next
// cycle. pop[k] is a one-cycle read strobe that is only asserted while
// empty[k] is low; the popped word is presented on data_out one cycle later.
interface generador_trafico_if #(
  parameter int DATA_W  = 6,
  parameter int CH_BITS = 1
);
  localparam int N = 1 << CH_BITS;

  logic                MAIN_FIFO_pause;
  logic [N-1:0]        empty;
  logic [N*DATA_W-1:0] data_out;
  logic [DATA_W-1:0]   data_in;
  logic                push_data_in;
  logic [N-1:0]        pop;

  modport master (
    input  MAIN_FIFO_pause, empty, data_out,
    output data_in, push_data_in, pop
  );

  modport slave (
    output MAIN_FIFO_pause, empty, data_out,
    input  data_in, push_data_in, pop
  );
endinterface

// File: rtl/generador_trafico_verificador_canal.sv
// Per-destination checker. Holds the expected sequence for one channel,
// delays the pop strobe by the device read latency and compares the word.
//   clk, reset : clock and asynchronous active-high reset
//   clr_i      : restart of a run; expected sequence back to 1, pending check dropped
//   pop_i      : pop strobe issued to this channel
//   data_i     : this channel's device output
//   ok_o/err_o : one-cycle result pulse of a check
module verificador_canal
  import generador_trafico_pkg::*;
#(
  parameter int DATA_W  = 6,
  parameter int CH_BITS = 1,
  parameter int CH      = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ok_o,
  output logic              err_o
);
  localparam int SEQ_W = DATA_W - CH_BITS;

  logic [SEQ_W-1:0]  exp_q, exp_d;
  logic              pop_q, pop_d;
  logic [DATA_W-1:0] word_exp;
  logic              match;

  always_comb begin
    word_exp = DATA_W'(make_word(32'(CH), 32'(exp_q), SEQ_W));
    match    = (data_i == word_exp);
    ok_o     = pop_q & match;
    err_o    = pop_q & ~match;
    pop_d    = pop_i;
    exp_d    = exp_q;
    if (clr_i) begin
      pop_d = 1'b0;
      exp_d = SEQ_W'(1);
    end else if (pop_q) begin
      // Advance on every checked word, good or bad, so a single corrupted
      // word does not shift the rest of the sequence.
      exp_d = exp_q + SEQ_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q <= SEQ_W'(1);
      pop_q <= 1'b0;
    end else begin
      exp_q <= exp_d;
      pop_q <= pop_d;
    end
  end

endmodule

// File: rtl/generador_trafico.sv
// Traffic generator and checker for the interconnect device. For each
// destination channel in turn it pushes a sequence-numbered burst (FILL),
// idles one cycle (GAP) and drains the channel (DRAIN). In auto mode it
// also pops during FILL. Every popped word is checked by a per-channel
// verificador_canal; pushed/popped/error totals saturate at all-ones.
//   clk, reset    : clock and asynchronous active-high reset
//   start         : one-cycle pulse, accepted in IDLE or DONE
//   auto_mode     : sampled on start; 1 = pop during FILL as well
//   dev           : device bus (master side)
//   busy, done    : run in progress / run finished
//   pushed, popped, errors : saturating totals of the current run
//   dbg_state_o   : current FSM state
module generador_trafico
  import generador_trafico_pkg::*;
#(
  parameter int DATA_W  = 6,
  parameter int CH_BITS = 1,
  parameter int BURST   = 24,
  parameter int DRAIN   = 24,
  parameter int CNT_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                auto_mode,
  generador_trafico_if.master dev,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    pushed,
  output logic [CNT_W-1:0]    popped,
  output logic [CNT_W-1:0]    errors,
  output state_t              dbg_state_o
);
  localparam int N     = 1 << CH_BITS;
  localparam int SEQ_W = DATA_W - CH_BITS;
  localparam int MAXC  = (BURST > DRAIN) ? BURST : DRAIN;
  localparam int CYC_W = $clog2(MAXC + 1);

  state_t             state_q, state_d;
  logic [CH_BITS-1:0] ch_q, ch_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic               auto_q, auto_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               push_q, push_d;
  logic [CNT_W-1:0]   pushed_q, pushed_d;
  logic [CNT_W-1:0]   popped_q, popped_d;
  logic [CNT_W-1:0]   errors_q, errors_d;

  logic               start_ok;
  logic [N-1:0]       pop_w;
  logic [N-1:0]       chk_ok;
  logic [N-1:0]       chk_err;

  assign start_ok = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));

  // FSM next state and push generator
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cyc_d   = cyc_q;
    auto_d  = auto_q;
    seq_d   = seq_q;
    push_d  = 1'b0;
    data_d  = '0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_d = ST_FILL;
          ch_d    = '0;
          cyc_d   = '0;
          auto_d  = auto_mode;
          seq_d   = SEQ_W'(1);
        end
      end
      ST_FILL: begin
        if (!dev.MAIN_FIFO_pause) begin
          push_d = 1'b1;
          data_d = DATA_W'(make_word(32'(ch_q), 32'(seq_q), SEQ_W));
          seq_d  = seq_q + SEQ_W'(1);
        end
        if (cyc_q == CYC_W'(BURST - 1)) begin
          state_d = ST_GAP;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_GAP: begin
        state_d = ST_DRAIN;
        cyc_d   = '0;
      end
      ST_DRAIN: begin
        if (cyc_q == CYC_W'(DRAIN - 1)) begin
          cyc_d = '0;
          if (ch_q == CH_BITS'(N - 1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FILL;
            ch_d    = ch_q + CH_BITS'(1);
            seq_d   = SEQ_W'(1);
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pops are combinational so a freshly non-empty FIFO is read at once.
  always_comb begin
    pop_w = '0;
    for (int k = 0; k < N; k++) begin
      pop_w[k] = (ch_q == CH_BITS'(k)) & ~dev.empty[k] &
                 ((state_q == ST_DRAIN) | (auto_q & (state_q == ST_FILL)));
    end
  end

  // Saturating statistics; a start clears them for the new run.
  always_comb begin
    pushed_d = pushed_q;
    popped_d = popped_q;
    errors_d = errors_q;
    if (start_ok) begin
      pushed_d = '0;
      popped_d = '0;
      errors_d = '0;
    end else begin
      if (push_d && !(&pushed_q))                popped_d = popped_q;
      if (push_d && !(&pushed_q))                pushed_d = pushed_q + CNT_W'(1);
      if ((|chk_ok || |chk_err) && !(&popped_q)) popped_d = popped_q + CNT_W'(1);
      if (|chk_err && !(&errors_q))              errors_d = errors_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ch_q     <= '0;
      cyc_q    <= '0;
      auto_q   <= 1'b0;
      seq_q    <= SEQ_W'(1);
      data_q   <= '0;
      push_q   <= 1'b0;
      pushed_q <= '0;
      popped_q <= '0;
      errors_q <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cyc_q    <= cyc_d;
      auto_q   <= auto_d;
      seq_q    <= seq_d;
      data_q   <= data_d;
      push_q   <= push_d;
      pushed_q <= pushed_d;
      popped_q <= popped_d;
      errors_q <= errors_d;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_chk
    verificador_canal #(
      .DATA_W  (DATA_W),
      .CH_BITS (CH_BITS),
      .CH      (k)
    ) u_chk (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (start_ok),
      .pop_i  (pop_w[k]),
      .data_i (dev.data_out[k*DATA_W +: DATA_W]),
      .ok_o   (chk_ok[k]),
      .err_o  (chk_err[k])
    );
  end

  assign dev.data_in      = data_q;
  assign dev.push_data_in = push_q;
  assign dev.pop          = pop_w;
  assign busy             = (state_q == ST_FILL) | (state_q == ST_GAP) | (state_q == ST_DRAIN);
  assign done             = (state_q == ST_DONE);
  assign pushed           = pushed_q;
  assign popped           = popped_q;
  assign errors           = errors_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_generador_trafico.sv
module tb_generador_trafico;
  import generador_trafico_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic start0 = 1'b0, auto0 = 1'b0, start1 = 1'b0, auto1 = 1'b0;
  logic busy0, done0, busy1, done1;
  logic [7:0] pushed0, popped0, errors0, pushed1, popped1, errors1;
  state_t dbg0, dbg1;

  logic pause_force = 1'b0;
  logic depth_en    = 1'b0;
  logic corrupt_en  = 1'b0;

  int checks = 0;
  int errs   = 0;
  logic saw_fill_pop;
  int   max_occ0;

  logic [5:0] exp0_q[$];
  logic [7:0] exp1_q[$];

  generador_trafico_if #(.DATA_W(6), .CH_BITS(1)) if0 ();
  generador_trafico_if #(.DATA_W(8), .CH_BITS(2)) if1 ();

  generador_trafico dut0 (
    .clk(clk), .reset(reset), .start(start0), .auto_mode(auto0), .dev(if0),
    .busy(busy0), .done(done0), .pushed(pushed0), .popped(popped0),
    .errors(errors0), .dbg_state_o(dbg0)
  );

  generador_trafico #(.DATA_W(8), .CH_BITS(2), .BURST(70), .DRAIN(70), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .auto_mode(auto1), .dev(if1),
    .busy(busy1), .done(done1), .pushed(pushed1), .popped(popped1),
    .errors(errors1), .dbg_state_o(dbg1)
  );

  // ---------------- device model, instance 0 (2 channels x 6 bits) ----------------
  logic [5:0] m0_q [2][$];
  logic [5:0] m0_dout [2];
  int         m0_cnt [2];
  int         m0_pops1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        m0_q[k].delete();
        m0_dout[k] <= '0;
        m0_cnt[k]  <= 0;
      end
      m0_pops1 <= 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (if0.pop[k])
          m0_dout[k] <= m0_q[k].pop_front() ^
                        (((k == 1) && corrupt_en && (m0_pops1 == 2)) ? 6'h01 : 6'h00);
        if (if0.push_data_in && (int'(if0.data_in[5]) == k))
          m0_q[k].push_back(if0.data_in);
        m0_cnt[k] <= m0_cnt[k]
                     + ((if0.push_data_in && (int'(if0.data_in[5]) == k)) ? 1 : 0)
                     - (if0.pop[k] ? 1 : 0);
      end
      if (if0.pop[1]) m0_pops1 <= m0_pops1 + 1;
    end
  end

  always_comb begin
    if0.empty = '0;
    for (int k = 0; k < 2; k++) if0.empty[k] = (m0_cnt[k] == 0);
  end
  assign if0.data_out = {m0_dout[1], m0_dout[0]};
  assign if0.MAIN_FIFO_pause = pause_force |
         (depth_en & ((m0_cnt[0] + m0_cnt[1] + int'(if0.push_data_in)) >= 4));

  // ---------------- device model, instance 1 (4 channels x 8 bits) ----------------
  logic [7:0] m1_q [4][$];
  logic [7:0] m1_dout [4];
  int         m1_cnt [4];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        m1_q[k].delete();
        m1_dout[k] <= '0;
        m1_cnt[k]  <= 0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (if1.pop[k]) m1_dout[k] <= m1_q[k].pop_front();
        if (if1.push_data_in && (int'(if1.data_in[7:6]) == k))
          m1_q[k].push_back(if1.data_in);
        m1_cnt[k] <= m1_cnt[k]
                     + ((if1.push_data_in && (int'(if1.data_in[7:6]) == k)) ? 1 : 0)
                     - (if1.pop[k] ? 1 : 0);
      end
    end
  end

  always_comb begin
    if1.empty = '0;
    for (int k = 0; k < 4; k++) if1.empty[k] = (m1_cnt[k] == 0);
  end
  assign if1.data_out = {m1_dout[3], m1_dout[2], m1_dout[1], m1_dout[0]};
  assign if1.MAIN_FIFO_pause = 1'b0;

  // ---------------- driver tasks ----------------
  // One clock; sample #1 after the edge and run the push scoreboard and
  // the pop-on-empty monitor for both instances.
  task automatic tick();
    logic [5:0] e0;
    logic [7:0] e1;
    @(posedge clk);
    #1;
    if (if0.push_data_in) begin
      checks++;
      if (exp0_q.size() == 0) begin
        errs++;
        $display("FAIL sb0_extra_push: data_in=%0d, required no push", if0.data_in);
      end else begin
        e0 = exp0_q.pop_front();
        if (if0.data_in !== e0) begin
          errs++;
          $display("FAIL sb0_word: data_in=%0d required %0d", if0.data_in, e0);
        end
      end
    end
    if (if1.push_data_in) begin
      checks++;
      if (exp1_q.size() == 0) begin
        errs++;
        $display("FAIL sb1_extra_push: data_in=%0d, required no push", if1.data_in);
      end else begin
        e1 = exp1_q.pop_front();
        if (if1.data_in !== e1) begin
          errs++;
          $display("FAIL sb1_word: data_in=%0d required %0d", if1.data_in, e1);
        end
      end
    end
    if (|if0.pop) begin
      checks++;
      if ((if0.pop & if0.empty) !== 2'b00) begin
        errs++;
        $display("FAIL pop0_on_empty: pop=%b empty=%b required no pop on empty", if0.pop, if0.empty);
      end
      if (dbg0 == ST_FILL) saw_fill_pop = 1'b1;
    end
    if (|if1.pop) begin
      checks++;
      if ((if1.pop & if1.empty) !== 4'b0000) begin
        errs++;
        $display("FAIL pop1_on_empty: pop=%b empty=%b required no pop on empty", if1.pop, if1.empty);
      end
    end
    if (m0_cnt[0] + m0_cnt[1] > max_occ0) max_occ0 = m0_cnt[0] + m0_cnt[1];
  endtask

  task automatic do_start(input int sel, input logic a);
    if (sel == 0) begin start0 = 1'b1; auto0 = a; end
    else          begin start1 = 1'b1; auto1 = a; end
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Clock until done with a cycle budget; n = edges after the start edge.
  task automatic run_to_done(input int sel, output int n);
    n = 0;
    while (!((sel == 0) ? done0 : done1) && n < 5000) begin
      tick();
      n++;
    end
    checks++;
    if (!((sel == 0) ? done0 : done1)) begin
      errs++;
      $display("FAIL done_timeout: done=0 after %0d cycles, required done=1", n);
    end
  endtask

  // Expected push stream for instance 0: ch0 1..last0, ch1 33..56.
  task automatic load_exp0(input int last0);
    exp0_q.delete();
    for (int s = 1; s <= last0; s++) exp0_q.push_back(6'(s));
    for (int s = 1; s <= 24; s++)    exp0_q.push_back(6'(32 + s));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (if0.data_in !== 6'd0)   begin errs++; $display("FAIL rst_data_in: got %0d required 0", if0.data_in); end
    checks++; if (if0.push_data_in !== 1'b0) begin errs++; $display("FAIL rst_push: got %b required 0", if0.push_data_in); end
    checks++; if (if0.pop !== 2'b00)      begin errs++; $display("FAIL rst_pop: got %b required 00", if0.pop); end
    checks++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin errs++; $display("FAIL rst_busy_done: got %b%b required 00", busy0, done0); end
    checks++; if ({pushed0, popped0, errors0} !== 24'd0) begin errs++; $display("FAIL rst_counters: got %0d/%0d/%0d required 0/0/0", pushed0, popped0, errors0); end
    checks++; if (dbg0 !== ST_IDLE)       begin errs++; $display("FAIL rst_state: got %0d required IDLE", dbg0); end
    checks++; if (if1.push_data_in !== 1'b0 || busy1 !== 1'b0) begin errs++; $display("FAIL rst_dut1: push=%b busy=%b required 0 0", if1.push_data_in, busy1); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fill_drain();
    int n;
    do_reset();
    load_exp0(24);
    saw_fill_pop = 1'b0;
    do_start(0, 1'b0);
    run_to_done(0, n);
    checks++; if (n != 98) begin errs++; $display("FAIL basic_done_cycle: got %0d required 98", n); end
    tick(); tick();
    checks++; if (pushed0 !== 8'd48) begin errs++; $display("FAIL basic_pushed: got %0d required 48", pushed0); end
    checks++; if (popped0 !== 8'd48) begin errs++; $display("FAIL basic_popped: got %0d required 48", popped0); end
    checks++; if (errors0 !== 8'd0)  begin errs++; $display("FAIL basic_errors: got %0d required 0", errors0); end
    checks++; if (done0 !== 1'b1 || busy0 !== 1'b0) begin errs++; $display("FAIL basic_done_busy: got %b%b required 10", done0, busy0); end
    checks++; if (exp0_q.size() != 0) begin errs++; $display("FAIL basic_missing_push: %0d words left required 0", exp0_q.size()); end
    checks++; if (saw_fill_pop !== 1'b0) begin errs++; $display("FAIL basic_fill_pop: got %b required 0", saw_fill_pop); end
  endtask

  // Restarted straight from DONE; pause held on FILL cycles 4..7 of channel 0.
  task automatic test_pause();
    int n;
    load_exp0(20);
    do_start(0, 1'b0);
    tick(); tick(); tick();
    pause_force = 1'b1;
    tick(); tick(); tick(); tick();
    pause_force = 1'b0;
    run_to_done(0, n);
    tick(); tick();
    checks++; if (pushed0 !== 8'd44) begin errs++; $display("FAIL pause_pushed: got %0d required 44", pushed0); end
    checks++; if (popped0 !== 8'd44) begin errs++; $display("FAIL pause_popped: got %0d required 44", popped0); end
    checks++; if (errors0 !== 8'd0)  begin errs++; $display("FAIL pause_errors: got %0d required 0", errors0); end
    checks++; if (exp0_q.size() != 0) begin errs++; $display("FAIL pause_missing_push: %0d words left required 0", exp0_q.size()); end
  endtask

  // Third word on channel 1 corrupted; a start pulse while busy is ignored.
  task automatic test_corrupt();
    int n;
    do_reset();
    load_exp0(24);
    corrupt_en = 1'b1;
    do_start(0, 1'b0);
    for (int i = 0; i < 30; i++) tick();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    run_to_done(0, n);
    checks++; if (n != 67) begin errs++; $display("FAIL busy_start_ignored: done after %0d more cycles required 67", n); end
    tick(); tick();
    corrupt_en = 1'b0;
    checks++; if (errors0 !== 8'd1)  begin errs++; $display("FAIL corrupt_errors: got %0d required 1", errors0); end
    checks++; if (popped0 !== 8'd48) begin errs++; $display("FAIL corrupt_popped: got %0d required 48", popped0); end
    checks++; if (pushed0 !== 8'd48) begin errs++; $display("FAIL corrupt_pushed: got %0d required 48", pushed0); end
  endtask

  task automatic test_auto_depth();
    int n;
    do_reset();
    load_exp0(24);
    depth_en = 1'b1;
    saw_fill_pop = 1'b0;
    max_occ0 = 0;
    do_start(0, 1'b1);
    run_to_done(0, n);
    tick(); tick();
    depth_en = 1'b0;
    checks++; if (errors0 !== 8'd0)  begin errs++; $display("FAIL auto_errors: got %0d required 0", errors0); end
    checks++; if (popped0 !== 8'd48) begin errs++; $display("FAIL auto_popped: got %0d required 48", popped0); end
    checks++; if (saw_fill_pop !== 1'b1) begin errs++; $display("FAIL auto_fill_pop: got %b required 1", saw_fill_pop); end
    checks++; if (max_occ0 > 4) begin errs++; $display("FAIL auto_overflow: occupancy %0d required at most 4", max_occ0); end
    checks++; if (exp0_q.size() != 0) begin errs++; $display("FAIL auto_missing_push: %0d words left required 0", exp0_q.size()); end
  endtask

  // 8-bit words, 4 channels, 70-word bursts: sequence wraps 63 -> 0 -> 1 and
  // the 8-bit counters saturate at 255 (280 words moved).
  task automatic test_wrap();
    int n;
    do_reset();
    exp1_q.delete();
    for (int k = 0; k < 4; k++)
      for (int s = 1; s <= 70; s++) exp1_q.push_back(8'(k * 64 + (s % 64)));
    do_start(1, 1'b0);
    run_to_done(1, n);
    checks++; if (n != 564) begin errs++; $display("FAIL wrap_done_cycle: got %0d required 564", n); end
    tick(); tick();
    checks++; if (errors1 !== 8'd0)   begin errs++; $display("FAIL wrap_errors: got %0d required 0", errors1); end
    checks++; if (pushed1 !== 8'd255) begin errs++; $display("FAIL wrap_pushed_sat: got %0d required 255", pushed1); end
    checks++; if (popped1 !== 8'd255) begin errs++; $display("FAIL wrap_popped_sat: got %0d required 255", popped1); end
    checks++; if (exp1_q.size() != 0) begin errs++; $display("FAIL wrap_missing_push: %0d words left required 0", exp1_q.size()); end
  endtask

  task automatic test_reset_mid_run();
    int n;
    do_reset();
    load_exp0(24);
    do_start(0, 1'b0);
    n = 0;
    while (dbg0 != ST_DRAIN && n < 200) begin tick(); n++; end
    checks++; if (dbg0 !== ST_DRAIN) begin errs++; $display("FAIL midrst_reach_drain: state %0d required DRAIN", dbg0); end
    tick(); tick(); tick();
    #2 reset = 1'b1;
    #1;
    checks++; if (if0.push_data_in !== 1'b0 || if0.data_in !== 6'd0) begin errs++; $display("FAIL midrst_push: push=%b data=%0d required 0 0", if0.push_data_in, if0.data_in); end
    checks++; if (if0.pop !== 2'b00) begin errs++; $display("FAIL midrst_pop: got %b required 00", if0.pop); end
    checks++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin errs++; $display("FAIL midrst_busy_done: got %b%b required 00", busy0, done0); end
    checks++; if ({pushed0, popped0, errors0} !== 24'd0) begin errs++; $display("FAIL midrst_counters: got %0d/%0d/%0d required 0/0/0", pushed0, popped0, errors0); end
    tick();
    checks++; if (if0.push_data_in !== 1'b0 || if0.pop !== 2'b00) begin errs++; $display("FAIL midrst_trailing: push=%b pop=%b required 0 00", if0.push_data_in, if0.pop); end
    reset = 1'b0;
    tick();
    load_exp0(24);
    do_start(0, 1'b0);
    run_to_done(0, n);
    checks++; if (n != 98) begin errs++; $display("FAIL rerun_done_cycle: got %0d required 98", n); end
    tick(); tick();
    checks++; if (pushed0 !== 8'd48 || popped0 !== 8'd48 || errors0 !== 8'd0) begin errs++; $display("FAIL rerun_totals: got %0d/%0d/%0d required 48/48/0", pushed0, popped0, errors0); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_fill_drain();
    test_pause();
    test_corrupt();
    test_auto_depth();
    test_wrap();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
